// File: rtl/ioctl_fb_loader.sv
// ioctl_fb_loader: turns the hps_io ioctl byte stream of an OSD file load into
// little-endian packed framebuffer words and queues them for a ready/valid RAM
// write port, with busy/done pulses and sticky error flags.
module ioctl_fb_loader #(
    parameter int unsigned WORD_BYTES = 2,
    parameter int unsigned ADDR_W     = 16,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter logic [7:0]  INDEX      = 8'd1,
    parameter int unsigned MAX_BYTES  = 76800
) (
    input  logic                    clk_sys,
    input  logic                    reset_n,
    input  logic                    ioctl_download,
    input  logic [7:0]              ioctl_index,
    input  logic                    ioctl_wr,
    input  logic [26:0]             ioctl_addr,
    input  logic [7:0]              ioctl_dout,
    output logic                    mem_wr,
    input  logic                    mem_ready,
    output logic [ADDR_W-1:0]       mem_addr,
    output logic [8*WORD_BYTES-1:0] mem_data,
    output logic [WORD_BYTES-1:0]   mem_be,
    output logic                    busy,
    output logic                    done,
    output logic [26:0]             byte_count,
    output logic                    err_gap,
    output logic                    err_size,
    output logic                    err_ovf
);

    localparam int unsigned LB = $clog2(WORD_BYTES);
    localparam int unsigned LW = (LB == 0) ? 1 : LB;
    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned DW = 8 * WORD_BYTES;
    localparam logic [26:0] MAX_ADDR  = MAX_BYTES[26:0];
    localparam logic [PW:0] DEPTH_C   = FIFO_DEPTH[PW:0];
    localparam logic [LW-1:0] LAST_LANE = LW'(WORD_BYTES - 1);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_FLUSH, S_DONE} state_t;

    state_t state, next_state;

    logic                  dl_q;
    logic [26:0]           expected_addr;
    logic [DW-1:0]         lane_data;
    logic [WORD_BYTES-1:0] be_acc;
    logic [ADDR_W-1:0]     word_addr_q;

    logic [ADDR_W-1:0]     fifo_addr [FIFO_DEPTH];
    logic [DW-1:0]         fifo_data [FIFO_DEPTH];
    logic [WORD_BYTES-1:0] fifo_be   [FIFO_DEPTH];
    logic [PW-1:0]         wr_ptr, rd_ptr;
    logic [PW:0]           fifo_count;

    logic                  start, byte_ok, gap_hit, size_hit;
    logic [LW-1:0]         lane;
    logic [ADDR_W-1:0]     word_addr_in;
    logic [DW-1:0]         merged_data;
    logic [WORD_BYTES-1:0] merged_be;
    logic                  word_push, flush_push, push_req, push_ok, pop, full, ovf_hit;
    logic [ADDR_W-1:0]     push_addr;
    logic [DW-1:0]         push_data;
    logic [WORD_BYTES-1:0] push_be;

    assign start        = (state == S_IDLE) && ioctl_download && !dl_q && (ioctl_index == INDEX);
    assign lane         = (WORD_BYTES == 1) ? '0 : ioctl_addr[LW-1:0];
    assign word_addr_in = ioctl_addr[ADDR_W+LB-1:LB];

    // Classify the incoming byte: gap first, then size limit, else it is accepted.
    always_comb begin
        byte_ok  = 1'b0;
        gap_hit  = 1'b0;
        size_hit = 1'b0;
        if (state == S_LOAD && ioctl_wr) begin
            if (ioctl_addr != expected_addr) begin
                gap_hit = 1'b1;
            end else if (ioctl_addr >= MAX_ADDR) begin
                size_hit = 1'b1;
            end else begin
                byte_ok = 1'b1;
            end
        end
    end

    // Merge the incoming byte into the lanes and pick what (if anything) gets pushed.
    always_comb begin
        merged_data = lane_data;
        merged_data[8*int'(lane) +: 8] = ioctl_dout;
        merged_be   = be_acc | (WORD_BYTES'(1) << lane);
        word_push   = byte_ok && (lane == LAST_LANE);
        flush_push  = (state == S_FLUSH) && (be_acc != '0);
        push_req    = word_push || flush_push;
        push_addr   = word_push ? word_addr_in : word_addr_q;
        push_data   = word_push ? merged_data  : lane_data;
        push_be     = word_push ? merged_be    : be_acc;
        pop         = (fifo_count != '0) && mem_ready;
        full        = (fifo_count == DEPTH_C);
        push_ok     = push_req && (!full || pop);
        ovf_hit     = push_req && full && !pop;
    end

    // State register.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; FLUSH waits until nothing is pending and the FIFO has drained.
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:  if (start) next_state = S_LOAD;
            S_LOAD:  if (!ioctl_download) next_state = S_FLUSH;
            S_FLUSH: if (be_acc == '0 && fifo_count == '0) next_state = S_DONE;
            S_DONE:  next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    // Status outputs decoded from the state.
    always_comb begin
        busy = (state != S_IDLE);
        done = (state == S_DONE);
    end

    // Load datapath: lanes, byte counter, expected address and sticky errors.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            dl_q          <= 1'b0;
            expected_addr <= '0;
            lane_data     <= '0;
            be_acc        <= '0;
            word_addr_q   <= '0;
            byte_count    <= '0;
            err_gap       <= 1'b0;
            err_size      <= 1'b0;
            err_ovf       <= 1'b0;
        end else begin
            dl_q <= ioctl_download;
            if (start) begin
                expected_addr <= '0;
                lane_data     <= '0;
                be_acc        <= '0;
                word_addr_q   <= '0;
                byte_count    <= '0;
                err_gap       <= 1'b0;
                err_size      <= 1'b0;
                err_ovf       <= 1'b0;
            end else begin
                if (gap_hit)  err_gap  <= 1'b1;
                if (size_hit) err_size <= 1'b1;
                if (ovf_hit)  err_ovf  <= 1'b1;
                if (byte_ok) begin
                    lane_data     <= merged_data;
                    be_acc        <= word_push ? '0 : merged_be;
                    word_addr_q   <= word_addr_in;
                    byte_count    <= byte_count + 27'd1;
                    expected_addr <= expected_addr + 27'd1;
                end else if (flush_push) begin
                    be_acc <= '0;
                end
            end
        end
    end

    // FIFO pointers and occupancy; a simultaneous push and pop leaves the count alone.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PW'(1);
            if (pop)     rd_ptr <= rd_ptr + PW'(1);
            case ({push_ok, pop})
                2'b10:   fifo_count <= fifo_count + (PW+1)'(1);
                2'b01:   fifo_count <= fifo_count - (PW+1)'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // FIFO storage; contents are only meaningful below the occupancy count.
    always_ff @(posedge clk_sys) begin
        if (push_ok) begin
            fifo_addr[wr_ptr] <= push_addr;
            fifo_data[wr_ptr] <= push_data;
            fifo_be[wr_ptr]   <= push_be;
        end
    end

    assign mem_wr   = (fifo_count != '0);
    assign mem_addr = fifo_addr[rd_ptr];
    assign mem_data = fifo_data[rd_ptr];
    assign mem_be   = fifo_be[rd_ptr];

endmodule
